// File: rtl/smm_operand_loader.sv
// rtl/smm_operand_loader.sv - streams 18 elements into A/B, pulses SMM reset, waits LAT cycles, presents result
module smm_operand_loader #(
    parameter int BW  = 8,
    parameter int LAT = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [BW-1:0] in_data,
    output logic          in_ready,
    output logic [BW-1:0] A [3][3],
    output logic [BW-1:0] B [3][3],
    output logic          smm_rst_n,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] RUN_INIT = 8'(LAT - 1);
    localparam logic [4:0] LAST_K   = 5'd17;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] k;
    logic [7:0] run_cnt;
    logic       accept;
    logic       last_elem;

    assign accept    = in_valid && in_ready;
    assign last_elem = accept && (k == LAST_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (last_elem) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN:     if (run_cnt == 8'd0) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        busy      = (state != LOAD);
        res_valid = (state == DONE);
        smm_rst_n = rst_n && (state != CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 5'd0;
        end else if (accept) begin
            k <= last_elem ? 5'd0 : k + 5'd1;
        end
    end

    // Loaded while the SMM is held in reset so RUN counts exactly LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= 8'd0;
        end else if (state == CLEAR) begin
            run_cnt <= RUN_INIT;
        end else if (state == RUN && run_cnt != 8'd0) begin
            run_cnt <= run_cnt - 8'd1;
        end
    end

    // accept implies LOAD, so the operands stay frozen for the whole multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    A[i][j] <= '0;
                    B[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    if (k == 5'(3 * i + j)) A[i][j] <= in_data;
                    if (k == 5'(9 + 3 * i + j)) B[i][j] <= in_data;
                end
            end
        end
    end

endmodule
